// File: rtl/fft_pkg.sv
// Shared constants and pipeline-entry type for the shared FP multiplier scheduler.
package fft_pkg;

  localparam int unsigned FP_W         = 32;
  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_PIPE_LAT = 3;
  localparam int unsigned MAX_NUM_REQ  = 8;
  // Requester ID width, sized for the largest legal NUM_REQ so every instance fits.
  localparam int unsigned ID_W         = $clog2(MAX_NUM_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [FP_W-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/fp_multiplier.sv
// Combinational IEEE-754 single multiply: truncated mantissa, zero-magnitude
// inputs give +0, no overflow/underflow/NaN handling.
module fp_multiplier
  import fft_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] product_c
);

  logic [47:0] mant_prod;
  logic [7:0]  exp_sum;
  logic        norm;
  logic        unused_lsbs;

  always_comb begin : mul_core
    mant_prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    norm      = mant_prod[47];
    exp_sum   = a[30:23] + b[30:23] - 8'd127 + 8'(norm);
    product_c = {a[31] ^ b[31], exp_sum, norm ? mant_prod[46:24] : mant_prod[45:23]};
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) begin
      product_c = '0;
    end
  end

  // Truncated product bits are intentionally dropped.
  assign unused_lsbs = ^mant_prod[22:0];

endmodule

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one FP multiplier among NUM_REQ requesters,
// with a fixed-latency, non-stalling result pipeline.
module fp_mul_scheduler
  import fft_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_data,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned LAST  = PIPE_LAT - 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             accept;
  logic [FP_W-1:0]  sel_a, sel_b;
  logic [FP_W-1:0]  op_a, op_b;
  logic [FP_W-1:0]  mul_a, mul_b;
  logic [FP_W-1:0]  product;

  pipe_entry_t stage    [PIPE_LAT];
  pipe_entry_t stage_in [PIPE_LAT];

  // Round-robin search from rr_ptr; first valid requester wins.
  always_comb begin : arbiter
    logic             found;
    logic [PTR_W-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        gnt_idx        = idx;
        req_ready[idx] = 1'b1;
      end
    end
    if (rst) begin
      req_ready = '0;
    end
  end

  assign accept = |req_ready;

  always_comb begin : operand_mux
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk) begin : rr_reg
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= PTR_W'((32'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  // Stage-1 operand registers; unused when the product is captured directly.
  always_ff @(posedge clk) begin : operand_regs
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= sel_a;
      op_b <= sel_b;
    end
  end

  assign mul_a = (PIPE_LAT == 1) ? sel_a : op_a;
  assign mul_b = (PIPE_LAT == 1) ? sel_b : op_b;

  fp_multiplier u_mul (
    .a         (mul_a),
    .b         (mul_b),
    .product_c (product)
  );

  // Next value of every stage; the output stage keeps its data when nothing emerges.
  always_comb begin : stage_feed
    for (int unsigned s = 0; s < PIPE_LAT; s++) begin
      stage_in[s] = '0;
    end
    stage_in[0].valid = accept;
    stage_in[0].id    = ID_W'(gnt_idx);
    stage_in[0].data  = (PIPE_LAT == 1) ? product : '0;
    for (int unsigned s = 1; s < PIPE_LAT; s++) begin
      stage_in[s].valid = stage[s-1].valid;
      stage_in[s].id    = stage[s-1].id;
      stage_in[s].data  = (s == 1) ? product : stage[s-1].data;
    end
    if (!stage_in[LAST].valid) begin
      stage_in[LAST].data = stage[LAST].data;
    end
  end

  always_ff @(posedge clk) begin : pipe_regs
    for (int unsigned s = 0; s < PIPE_LAT; s++) begin
      if (rst) begin
        stage[s] <= '0;
      end else begin
        stage[s] <= stage_in[s];
      end
    end
  end

  // Reset also discards the entry currently sitting in the output stage.
  always_comb begin : rsp_decode
    rsp_valid = '0;
    busy      = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = stage[LAST].valid && (stage[LAST].id == ID_W'(i)) && !rst;
    end
    for (int unsigned s = 0; s < PIPE_LAT; s++) begin
      busy = busy | stage[s].valid;
    end
  end

  assign rsp_data = stage[LAST].data;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_fp_mul_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int PIPE_LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   v;
  logic [31:0]  a_in [4];
  logic [31:0]  b_in [4];
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always_comb begin
    req_a = {a_in[3], a_in[2], a_in[1], a_in[0]};
    req_b = {b_in[3], b_in[2], b_in[1], b_in[0]};
  end

  always #5 clk = ~clk;

  fp_mul_scheduler #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          m_ptr = 0;
  int          cyc   = 0;
  logic [3:0]  m_out_valid = '0;
  logic [31:0] m_out_data  = '0;
  bit          started = 1'b0;

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    if (x[30:0] == 31'd0 || y[30:0] == 31'd0) return 32'h0;
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p >= 48'h8000_0000_0000) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {x[31] ^ y[31], 8'(e), m};
  endfunction

  function automatic int pick(input logic [3:0] vv, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [1:0] j;
      j = 2'((ptr + k) % NUM_REQ);
      if (vv[j]) return int'(j);
    end
    return -1;
  endfunction

  initial forever begin
    int   g;
    exp_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr       = 0;
      m_out_valid = '0;
      m_out_data  = '0;
      started     = 1'b1;
    end else begin
      g = pick(v, m_ptr);
      if (g >= 0) begin
        e.due  = cyc + PIPE_LAT;
        e.id   = g;
        e.data = fmul(a_in[2'(g)], b_in[2'(g)]);
        q.push_back(e);
        m_ptr = (g + 1) % NUM_REQ;
      end
      m_out_valid = '0;
    end
    cyc++;
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      m_out_valid = 4'(1 << q[0].id);
      m_out_data  = q[0].data;
      void'(q.pop_front());
    end
  end

  initial forever begin
    int         g;
    logic [3:0] er;
    @(negedge clk);
    if (started) begin
      g  = pick(v, m_ptr);
      er = (rst || g < 0) ? 4'b0 : 4'(1 << g);
      chk("model_req_ready", 32'(req_ready), 32'(er));
      chk("model_rsp_valid", 32'(rsp_valid), rst ? 32'h0 : 32'(m_out_valid));
      if (!rst && m_out_valid != 4'b0) chk("model_rsp_data", rsp_data, m_out_data);
      chk("model_busy", 32'(busy), 32'(q.size() != 0 || m_out_valid != 4'b0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_tab   [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] lat1_tab [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
  logic [3:0] pair_tab [3] = '{4'b0000, 4'b0100, 4'b1000};

  initial begin
    v = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // single request, first cycle out of reset: 2.0 * 3.0
    next_cycle();
    rst = 1'b0;
    v = 4'b0001; a_in[0] = 32'h4000_0000; b_in[0] = 32'h4040_0000;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    next_cycle();
    v = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("single_rsp_valid", 32'(rsp_valid), 32'(lat1_tab[c-1]));
      if (c >= 3) chk("single_rsp_data", rsp_data, 32'h40C0_0000);
    end

    // sign and zero: requesters 2 and 3 from rr_ptr=1
    next_cycle();
    v = 4'b1100;
    a_in[2] = 32'h3FC0_0000; b_in[2] = 32'hC000_0000;
    a_in[3] = 32'h0000_0000; b_in[3] = 32'h4120_0000;
    @(negedge clk);
    chk("pair_ready2", 32'(req_ready), 32'h4);
    next_cycle();
    v = 4'b1000;
    @(negedge clk);
    chk("pair_ready3", 32'(req_ready), 32'h8);
    next_cycle();
    v = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("pair_rsp_valid", 32'(rsp_valid), 32'(pair_tab[c-1]));
      if (c == 2) chk("sign_product", rsp_data, 32'hC040_0000);
      if (c == 3) chk("zero_product", rsp_data, 32'h0000_0000);
    end

    // fairness from reset, all four held for 8 cycles
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    v = 4'b1111;
    a_in[0] = 32'h3F80_0000; b_in[0] = 32'h40A0_0000;
    a_in[1] = 32'h4040_0000; b_in[1] = 32'h4040_0000;
    a_in[2] = 32'hBF80_0000; b_in[2] = 32'h3F80_0000;
    a_in[3] = 32'h4000_0000; b_in[3] = 32'h4000_0000;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      chk("fair_ready", 32'(req_ready), c < 8 ? 32'(rr_tab[c]) : 32'h0);
      if (c >= 3) chk("fair_rsp_order", 32'(rsp_valid), 32'(rr_tab[c-3]));
      if (c == 4) chk("fair_product_9", rsp_data, 32'h4110_0000);
      next_cycle();
      if (c == 7) v = 4'b0000;
    end

    // skip: move pointer to 1, then 1001 grants 3 then 0
    v = 4'b0001;
    @(negedge clk);
    chk("skip_setup_ready", 32'(req_ready), 32'h1);
    next_cycle();
    v = 4'b1001;
    @(negedge clk);
    chk("skip_grant3", 32'(req_ready), 32'h8);
    next_cycle();
    @(negedge clk);
    chk("skip_grant0", 32'(req_ready), 32'h1);
    next_cycle();
    v = 4'b0000;
    repeat (4) next_cycle();

    // reset mid-flight: three accepts (pointer at 1), then a one-cycle reset
    v = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flight_ready", 32'(req_ready), c == 0 ? 32'h2 : (c == 1 ? 32'h4 : 32'h1));
      next_cycle();
    end
    v = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    chk("flight_rsp_in_reset", 32'(rsp_valid), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("flight_no_rsp", 32'(rsp_valid), 32'h0);
      if (c == 0) chk("flight_busy_cleared", 32'(busy), 32'h0);
      next_cycle();
    end
    v = 4'b0100; a_in[2] = 32'h4080_0000; b_in[2] = 32'h3F00_0000;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'h4);
    next_cycle();
    v = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", 32'(rsp_valid), c == 3 ? 32'h4 : 32'h0);
      if (c == 3) chk("post_reset_rsp_data", rsp_data, 32'h4000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
